pixel_frame_streamer: RTL and testbench
=======================================

Name: pixel_frame_streamer

Overview:
Parametrised successor to the single-mode LED data source. Fetches a programmable number of pixel words from the frame RAM and serialises each word MSB-first to the downstream bit encoder over a valid/ready handshake. Supports 24-bit (RGB) or 32-bit (RGBW) pixels, a configurable RAM read latency and reset-gap length, and an optional free-running repeat mode. Sits between the frame RAM and the NeoPixel bit-timing encoder.

Parameters:
ADDR_WIDTH, 6, RAM address width; max frame = 2**ADDR_WIDTH pixels
BITS_PER_PIXEL, 24, bits sent per pixel; legal values 24 or 32
RAM_LATENCY, 2, cycles from ram_rd_en high to ram_q valid; range 1..4
GAP_CYCLES, 10200, latch/reset gap length in clk_in cycles (51 us at 200 MHz)

Ports:
clk_in  input  1  sole clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
start  input  1  frame start pulse; honoured only in IDLE
repeat_en  input  1  when 1, a new frame starts automatically after the gap
pixel_count  input  ADDR_WIDTH+1  pixels per frame, sampled at frame start
ram_q  input  32  RAM read data; bits [BITS_PER_PIXEL-1:0] used
ram_rd_en  output  1  one-cycle RAM read strobe
ram_addr  output  ADDR_WIDTH  RAM read address
bit_valid  output  1  bit_data is valid
bit_data  output  1  current serial bit, MSB-first
bit_ready  input  1  encoder accepts the bit when bit_valid & bit_ready
busy  output  1  high from frame start until frame_done
frame_done  output  1  one-cycle pulse on the last gap cycle

Behaviour:
- Clock is clk_in. Reset rst_n_in is asynchronous and active-low. Reset values: all outputs 0, state IDLE, counters 0, ram_addr 0.
- Reset asserted mid-frame aborts immediately. bit_valid drops asynchronously. No frame_done is produced.
- States: IDLE, FETCH, SHIFT, GAP.
- IDLE: on start=1, latch pixel_count into an internal count register, set ram_addr=0 and busy=1. If the latched count is 0, go directly to GAP. Otherwise go to FETCH.
- FETCH: ram_rd_en=1 for exactly the first FETCH cycle, with the current ram_addr. Exactly RAM_LATENCY cycles after that strobe, capture ram_q[BITS_PER_PIXEL-1:0] into the shift register. In the same cycle, set the bit counter to 0, increment ram_addr (wraps modulo 2**ADDR_WIDTH) and enter SHIFT. bit_valid=0 throughout FETCH.
- SHIFT: bit_valid=1 and bit_data = shift-register MSB. Hold both stable while bit_ready=0.
- SHIFT transfer: on a cycle with bit_valid&bit_ready, shift left by one and increment the bit counter.
- SHIFT exit: on the transfer of bit BITS_PER_PIXEL-1, drop bit_valid in the next cycle. Then go to FETCH if pixels remain, otherwise to GAP.
- GAP: count GAP_CYCLES cycles with bit_valid=0. frame_done=1 on the final gap cycle.
- After GAP with repeat_en=1 (sampled on the final gap cycle): restart as if start were seen. pixel_count is re-sampled, ram_addr=0, busy stays 1.
- After GAP with repeat_en=0: go to IDLE and set busy=0 in the next cycle.
- start while busy=1 is ignored and not queued.
- Changes to pixel_count mid-frame have no effect.
- Minimum per-pixel overhead is RAM_LATENCY+1 cycles of bit_valid=0 between pixels. The encoder tolerates this overhead.
- Frame length in bits = latched count × BITS_PER_PIXEL.
- pixel_count = 2**ADDR_WIDTH is legal. The address wraps to 0 after the last pixel; that wrapped address is never read within the same frame.

Test Plan:
- Reset then start with pixel_count=2, BITS_PER_PIXEL=24, bit_ready always 1, RAM words 0xA5F00F and 0x123456 -> exactly 48 bits out, MSB-first, matching 101001011111000000001111 then 000100100011010001010110; ram_addr reads 0 then 1; frame_done pulses 10200 cycles after the last bit; busy falls the following cycle.
- BITS_PER_PIXEL=32, RAM_LATENCY=3, ram_q=0x80000001 -> 32 bits, first and last bit =1; bit data captured 3 cycles after the ram_rd_en strobe.
- bit_ready toggling with a 1-in-3 duty -> bit_data and bit_valid stay stable while ready=0; no bit is lost or duplicated; the sequence is identical to the ready=1 run.
- repeat_en=1 with pixel_count=1 -> back-to-back frames with ram_addr restarting at 0; frame_done pulses every frame; busy stays 1. De-asserting repeat_en ends activity after the current gap.
- pixel_count=0, and separately start pulsed while busy -> zero bits, frame_done after 10200 cycles; the extra start is ignored.
- rst_n_in low mid-pixel -> all outputs 0 immediately. After release, start with pixel_count=64 -> 64 reads, addresses 0..63, and ram_addr wraps to 0.

Source files
------------

// File: rtl/pixel_frame_streamer.sv
// Frame RAM to serial-bit streamer: fetches pixel words and shifts them out MSB-first
// over a valid/ready handshake, with a latch gap after each frame and optional repeat.
module pixel_frame_streamer #(
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned BITS_PER_PIXEL = 24,
  parameter int unsigned RAM_LATENCY    = 2,
  parameter int unsigned GAP_CYCLES     = 10200
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start,
  input  logic                  repeat_en,
  input  logic [ADDR_WIDTH:0]   pixel_count,
  input  logic [31:0]           ram_q,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  bit_valid,
  output logic                  bit_data,
  input  logic                  bit_ready,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned BIT_W = $clog2(BITS_PER_PIXEL);
  localparam int unsigned LAT_W = 3;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, GAP} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          rem_q, rem_d;
  logic [LAT_W-1:0]          lat_q, lat_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [GAP_W-1:0]          gap_q, gap_d;
  logic [BITS_PER_PIXEL-1:0] sreg_q, sreg_d;
  logic [ADDR_WIDTH-1:0]     addr_d;
  logic                      rd_en_d, valid_d, busy_d, done_d;

  logic last_gap, capture, transfer, last_bit, launch;
  logic unused_ram_bits;

  assign unused_ram_bits = ^ram_q;

  assign last_gap = (state_q == GAP) && (gap_q == GAP_W'(GAP_CYCLES - 1));
  assign capture  = (state_q == FETCH) && (lat_q == LAT_W'(RAM_LATENCY));
  assign transfer = (state_q == SHIFT) && bit_valid && bit_ready;
  assign last_bit = transfer && (bit_q == BIT_W'(BITS_PER_PIXEL - 1));
  // A repeat restart behaves exactly like a start seen in IDLE.
  assign launch   = ((state_q == IDLE) && start) || (last_gap && repeat_en);

  assign bit_data = sreg_q[BITS_PER_PIXEL-1];

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (pixel_count == CNT_W'(0)) ? GAP : FETCH;
      FETCH:   if (capture) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = (rem_q == CNT_W'(0)) ? GAP : FETCH;
      GAP:     if (last_gap) begin
                 if (!repeat_en)                     state_d = IDLE;
                 else if (pixel_count == CNT_W'(0))  state_d = GAP;
                 else                                state_d = FETCH;
               end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; outputs are registered from these
  always_comb begin
    rem_d   = rem_q;
    addr_d  = ram_addr;
    sreg_d  = sreg_q;
    bit_d   = bit_q;
    lat_d   = ((state_q == FETCH) && (state_d == FETCH)) ? lat_q + LAT_W'(1) : LAT_W'(0);
    gap_d   = GAP_W'(0);
    if ((state_d == GAP) && (state_q == GAP) && !last_gap) gap_d = gap_q + GAP_W'(1);
    rd_en_d = (state_d == FETCH) && (state_q != FETCH);
    valid_d = (state_d == SHIFT);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == GAP) && (gap_d == GAP_W'(GAP_CYCLES - 1));

    if (launch) begin
      rem_d  = pixel_count;
      addr_d = '0;
    end
    if (capture) begin
      sreg_d = ram_q[BITS_PER_PIXEL-1:0];
      bit_d  = BIT_W'(0);
      addr_d = ram_addr + ADDR_WIDTH'(1);
      rem_d  = rem_q - CNT_W'(1);
    end
    if (transfer) begin
      sreg_d = {sreg_q[BITS_PER_PIXEL-2:0], 1'b0};
      bit_d  = bit_q + BIT_W'(1);
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rem_q      <= '0;
      lat_q      <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      sreg_q     <= '0;
      ram_addr   <= '0;
      ram_rd_en  <= 1'b0;
      bit_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      rem_q      <= rem_d;
      lat_q      <= lat_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      sreg_q     <= sreg_d;
      ram_addr   <= addr_d;
      ram_rd_en  <= rd_en_d;
      bit_valid  <= valid_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Directed bench for pixel_frame_streamer: default 24-bit instance plus a 32-bit, latency-3 instance.
`timescale 1ns/1ps
module tb_pixel_frame_streamer;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_n_in;
  logic        start0, repeat0, ready0, rd0, valid0, data0, busy0, done0;
  logic [6:0]  pc0;
  logic [31:0] q0;
  logic [5:0]  addr0;
  logic        start1, repeat1, ready1, rd1, valid1, data1, busy1, done1;
  logic [6:0]  pc1;
  logic [31:0] q1;
  logic [5:0]  addr1;

  int n_checks = 0;
  int n_fail   = 0;

  pixel_frame_streamer u_dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start(start0), .repeat_en(repeat0),
    .pixel_count(pc0), .ram_q(q0), .ram_rd_en(rd0), .ram_addr(addr0),
    .bit_valid(valid0), .bit_data(data0), .bit_ready(ready0), .busy(busy0), .frame_done(done0)
  );

  pixel_frame_streamer #(.ADDR_WIDTH(6), .BITS_PER_PIXEL(32), .RAM_LATENCY(3), .GAP_CYCLES(16)) u_dut32 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start(start1), .repeat_en(repeat1),
    .pixel_count(pc1), .ram_q(q1), .ram_rd_en(rd1), .ram_addr(addr1),
    .bit_valid(valid1), .bit_data(data1), .bit_ready(ready1), .busy(busy1), .frame_done(done1)
  );

  // RAM models: data is valid only in the exact cycle RAM_LATENCY after the strobe
  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];
  logic [31:0] p0a, p1a, p1b;
  always @(posedge clk_in) begin
    p0a <= rd0 ? mem0[addr0] : 32'hDEAD_BEEF;
    q0  <= p0a;
    p1a <= rd1 ? mem1[addr1] : 32'h5A5A_A5A5;
    p1b <= p1a;
    q1  <= p1b;
  end

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitors (sole writers of their counters)
  int nbits0 = 0, last_bit_cyc0 = 0, done_cnt0 = 0, done_cyc0 = 0;
  int stall_err0 = 0, stalls0 = 0, busy_low0 = 0;
  logic [63:0] acc0 = '0;
  logic done_busy0 = 1'b0, pv0 = 1'b0, pr0 = 1'b0, pd0 = 1'b0;
  int addr_log0[$];
  always @(negedge clk_in) begin
    if (valid0 && ready0) begin
      acc0 <= {acc0[62:0], data0};
      nbits0 <= nbits0 + 1;
      last_bit_cyc0 <= cyc;
    end
    if (rd0) addr_log0.push_back(int'(addr0));
    if (done0) begin
      done_cnt0 <= done_cnt0 + 1;
      done_cyc0 <= cyc;
      done_busy0 <= busy0;
    end
    if (!busy0) busy_low0 <= busy_low0 + 1;
    if (pv0 && !pr0) begin
      stalls0 <= stalls0 + 1;
      if (!valid0 || (data0 !== pd0)) stall_err0 <= stall_err0 + 1;
    end
    pv0 <= valid0; pr0 <= ready0; pd0 <= data0;
  end

  int nbits1 = 0, last_bit_cyc1 = 0, done_cnt1 = 0, done_cyc1 = 0, first_valid_cyc1 = 0, rd_cyc1 = 0;
  logic [63:0] acc1 = '0;
  logic pv1 = 1'b0;
  always @(negedge clk_in) begin
    if (valid1 && ready1) begin
      acc1 <= {acc1[62:0], data1};
      nbits1 <= nbits1 + 1;
      last_bit_cyc1 <= cyc;
    end
    if (rd1) rd_cyc1 <= cyc;
    if (valid1 && !pv1) first_valid_cyc1 <= cyc;
    if (done1) begin
      done_cnt1 <= done_cnt1 + 1;
      done_cyc1 <= cyc;
    end
    pv1 <= valid1;
  end

  task automatic pulse_start0(input logic [6:0] n, output int s);
    @(posedge clk_in); #1;
    pc0 = n; start0 = 1'b1; s = cyc;
    @(posedge clk_in); #1;
    start0 = 1'b0;
  endtask

  task automatic pulse_start1(input logic [6:0] n);
    @(posedge clk_in); #1;
    pc1 = n; start1 = 1'b1;
    @(posedge clk_in); #1;
    start1 = 1'b0;
  endtask

  task automatic wait_done0(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk_in); #1;
      if (done_cnt0 >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done1(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk_in); #1;
      if (done_cnt1 >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    start0 = 0; repeat0 = 0; ready0 = 1; pc0 = '0;
    start1 = 0; repeat1 = 0; ready1 = 1; pc1 = '0;
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    n_checks++; if ({rd0, addr0, valid0, data0, busy0, done0} !== 11'd0) begin n_fail++;
      $display("FAIL reset_outputs0: got %0h expected 0", {rd0, addr0, valid0, data0, busy0, done0}); end
    n_checks++; if ({rd1, addr1, valid1, data1, busy1, done1} !== 11'd0) begin n_fail++;
      $display("FAIL reset_outputs1: got %0h expected 0", {rd1, addr1, valid1, data1, busy1, done1}); end
    rst_n_in = 1'b1;
  endtask

  task automatic test_basic();
    int n0, a0, d0, s; bit ok;
    mem0[0] = 32'h00A5F00F; mem0[1] = 32'h00123456;
    n0 = nbits0; a0 = addr_log0.size(); d0 = done_cnt0;
    ready0 = 1; repeat0 = 0;
    pulse_start0(7'd2, s);
    n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %0b expected 1", busy0); end
    wait_done0(d0 + 1, 12000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got no frame_done expected one"); end
    n_checks++; if (nbits0 - n0 != 48) begin n_fail++; $display("FAIL basic_nbits: got %0d expected 48", nbits0 - n0); end
    n_checks++; if (acc0[47:0] !== 48'hA5F00F123456) begin n_fail++;
      $display("FAIL basic_bits: got %0h expected a5f00f123456", acc0[47:0]); end
    n_checks++; if (addr_log0.size() - a0 != 2) begin n_fail++;
      $display("FAIL basic_nreads: got %0d expected 2", addr_log0.size() - a0); end
    else begin
      n_checks++; if (addr_log0[a0] != 0 || addr_log0[a0+1] != 1) begin n_fail++;
        $display("FAIL basic_addrs: got %0d,%0d expected 0,1", addr_log0[a0], addr_log0[a0+1]); end
    end
    n_checks++; if (done_cyc0 - last_bit_cyc0 != 10200) begin n_fail++;
      $display("FAIL basic_gap: got %0d expected 10200", done_cyc0 - last_bit_cyc0); end
    n_checks++; if (done_busy0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_at_done: got %0b expected 1", done_busy0); end
    n_checks++; if ({busy0, done0} !== 2'b00) begin n_fail++;
      $display("FAIL basic_after_done: got busy,done=%0b expected 00", {busy0, done0}); end
  endtask

  task automatic test_ready_toggle();
    int n0, d0, se0, st0, s;
    pulse_start0(7'd2, s);
    n0 = nbits0; d0 = done_cnt0; se0 = stall_err0; st0 = stalls0;
    for (int k = 0; k < 12000 && done_cnt0 < d0 + 1; k++) begin
      @(posedge clk_in); #1;
      ready0 = (k % 3 == 0);
    end
    ready0 = 1'b1;
    n_checks++; if (done_cnt0 != d0 + 1) begin n_fail++; $display("FAIL toggle_timeout: got %0d frames expected 1", done_cnt0 - d0); end
    n_checks++; if (nbits0 - n0 != 48) begin n_fail++; $display("FAIL toggle_nbits: got %0d expected 48", nbits0 - n0); end
    n_checks++; if (acc0[47:0] !== 48'hA5F00F123456) begin n_fail++;
      $display("FAIL toggle_bits: got %0h expected a5f00f123456", acc0[47:0]); end
    n_checks++; if (stall_err0 != se0) begin n_fail++; $display("FAIL toggle_stable: got %0d unstable stalls expected 0", stall_err0 - se0); end
    n_checks++; if (stalls0 - st0 < 48) begin n_fail++; $display("FAIL toggle_stalls_seen: got %0d expected >=48", stalls0 - st0); end
  endtask

  task automatic test_repeat();
    int n0, a0, d0, b0, s; bit ok1, ok2;
    mem0[0] = 32'h00C33C5A;
    n0 = nbits0; a0 = addr_log0.size(); d0 = done_cnt0;
    repeat0 = 1'b1;
    pulse_start0(7'd1, s);
    b0 = busy_low0;
    wait_done0(d0 + 1, 12000, ok1);
    repeat0 = 1'b0;
    wait_done0(d0 + 2, 12000, ok2);
    n_checks++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL repeat_timeout: got %0d frames expected 2", done_cnt0 - d0); end
    n_checks++; if (busy_low0 != b0) begin n_fail++; $display("FAIL repeat_busy_held: got %0d idle cycles expected 0", busy_low0 - b0); end
    n_checks++; if (addr_log0.size() - a0 != 2) begin n_fail++;
      $display("FAIL repeat_nreads: got %0d expected 2", addr_log0.size() - a0); end
    else begin
      n_checks++; if (addr_log0[a0] != 0 || addr_log0[a0+1] != 0) begin n_fail++;
        $display("FAIL repeat_addrs: got %0d,%0d expected 0,0", addr_log0[a0], addr_log0[a0+1]); end
    end
    n_checks++; if (acc0[47:0] !== 48'hC33C5AC33C5A || nbits0 - n0 != 48) begin n_fail++;
      $display("FAIL repeat_bits: got %0h/%0d expected c33c5ac33c5a/48", acc0[47:0], nbits0 - n0); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL repeat_end_busy: got %0b expected 0", busy0); end
    repeat (40) @(posedge clk_in);
    #1;
    n_checks++; if (addr_log0.size() - a0 != 2 || done_cnt0 != d0 + 2) begin n_fail++;
      $display("FAIL repeat_stopped: got %0d reads %0d frames expected 2 2", addr_log0.size() - a0, done_cnt0 - d0); end
  endtask

  task automatic test_zero_and_busy_start();
    int n0, a0, d0, s, s2; bit ok;
    n0 = nbits0; a0 = addr_log0.size(); d0 = done_cnt0;
    pulse_start0(7'd0, s);
    repeat (5) @(posedge clk_in);
    pulse_start0(7'd3, s2);
    wait_done0(d0 + 1, 10300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_timeout: got no frame_done expected one"); end
    n_checks++; if (done_cyc0 - s != 10200) begin n_fail++; $display("FAIL zero_gap: got %0d expected 10200", done_cyc0 - s); end
    n_checks++; if (nbits0 != n0) begin n_fail++; $display("FAIL zero_nbits: got %0d expected 0", nbits0 - n0); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after: got %0b expected 0", busy0); end
    repeat (30) @(posedge clk_in);
    #1;
    n_checks++; if (addr_log0.size() != a0 || busy0 !== 1'b0 || done_cnt0 != d0 + 1) begin n_fail++;
      $display("FAIL zero_start_ignored: got %0d reads busy=%0b %0d frames expected 0 0 1",
               addr_log0.size() - a0, busy0, done_cnt0 - d0); end
  endtask

  task automatic test_reset_mid_pixel();
    int d0, s; bit seen;
    mem0[0] = 32'h00FFFFFF;
    d0 = done_cnt0; seen = 1'b0;
    pulse_start0(7'd5, s);
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk_in); #1;
      seen = valid0;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL midrst_no_valid: got no bit_valid expected one"); end
    @(posedge clk_in); #1;
    @(posedge clk_in); #2;
    rst_n_in = 1'b0;
    #1;
    n_checks++; if ({rd0, addr0, valid0, data0, busy0, done0} !== 11'd0) begin n_fail++;
      $display("FAIL midrst_outputs: got %0h expected 0", {rd0, addr0, valid0, data0, busy0, done0}); end
    repeat (5) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    n_checks++; if (done_cnt0 != d0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", done_cnt0 - d0); end
  endtask

  task automatic test_full_frame();
    int n0, a0, d0, errs, s; bit ok;
    for (int i = 0; i < 64; i++) mem0[i] = {8'h00, 8'(i), 8'(~i), 8'(i * 3)};
    n0 = nbits0; a0 = addr_log0.size(); d0 = done_cnt0; errs = 0;
    pulse_start0(7'd64, s);
    wait_done0(d0 + 1, 13000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL full_timeout: got no frame_done expected one"); end
    n_checks++; if (addr_log0.size() - a0 != 64) begin n_fail++;
      $display("FAIL full_nreads: got %0d expected 64", addr_log0.size() - a0); end
    else begin
      for (int i = 0; i < 64; i++) if (addr_log0[a0+i] != i) errs++;
      n_checks++; if (errs != 0) begin n_fail++; $display("FAIL full_addrs: got %0d bad addresses expected 0", errs); end
    end
    n_checks++; if (nbits0 - n0 != 1536) begin n_fail++; $display("FAIL full_nbits: got %0d expected 1536", nbits0 - n0); end
    n_checks++; if (acc0[23:0] !== 24'h3FC0BD) begin n_fail++; $display("FAIL full_last_pixel: got %0h expected 3fc0bd", acc0[23:0]); end
    n_checks++; if (addr0 !== 6'd0) begin n_fail++; $display("FAIL full_addr_wrap: got %0d expected 0", addr0); end
  endtask

  task automatic test_wide();
    int n1, d1; bit ok;
    mem1[0] = 32'h80000001;
    n1 = nbits1; d1 = done_cnt1;
    pulse_start1(7'd1);
    wait_done1(d1 + 1, 300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wide_timeout: got no frame_done expected one"); end
    n_checks++; if (nbits1 - n1 != 32) begin n_fail++; $display("FAIL wide_nbits: got %0d expected 32", nbits1 - n1); end
    n_checks++; if (acc1[31:0] !== 32'h80000001) begin n_fail++; $display("FAIL wide_bits: got %0h expected 80000001", acc1[31:0]); end
    n_checks++; if (first_valid_cyc1 - rd_cyc1 != 4) begin n_fail++;
      $display("FAIL wide_latency: got %0d expected 4", first_valid_cyc1 - rd_cyc1); end
    n_checks++; if (done_cyc1 - last_bit_cyc1 != 16) begin n_fail++;
      $display("FAIL wide_gap: got %0d expected 16", done_cyc1 - last_bit_cyc1); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin mem0[i] = 32'h0; mem1[i] = 32'h0; end
    test_reset();
    test_basic();
    test_ready_toggle();
    test_repeat();
    test_zero_and_busy_start();
    test_reset_mid_pixel();
    test_full_frame();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $fatal(1, "watchdog");
  end

endmodule
